// File: rtl/vcb_pkg.sv
// Shared types and constants for the VCB cascadable counter family.
package vcb_pkg;

    typedef enum logic {VCB_RUN, VCB_HOLD} vcb_state_t;

    localparam int unsigned VCB_RST_Q = 0;

endpackage

// File: rtl/vcb_mod_step.sv
// Combinational next-value logic for one programmable-modulus counter step.
module vcb_mod_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] q_next,
    output logic             is_tc,
    output logic             is_wrap
);

    always_comb begin
        q_next  = q;
        is_wrap = 1'b0;
        // Counting up, anything at or above mod_max is terminal (covers loads past the modulus).
        is_tc   = up ? (q >= mod_max) : (q == '0);
        if (up) begin
            if (!is_tc) begin
                q_next = q + WIDTH'(1);
            end else if (sat) begin
                q_next = mod_max;
            end else begin
                q_next  = '0;
                is_wrap = 1'b1;
            end
        end else begin
            if (!is_tc) begin
                q_next = q - WIDTH'(1);
            end else if (sat) begin
                q_next = '0;
            end else begin
                q_next  = mod_max;
                is_wrap = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vcb_mod_cled.sv
// Loadable up/down counter with programmable modulus, wrap/saturate, one-shot HOLD and cascade.
// Optional compare-match pulse output when VCB_MATCH_EN is defined.
module vcb_mod_cled
    import vcb_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter bit          ONE_SHOT_DEF = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic             up,
    input  logic             l,
    input  logic [WIDTH-1:0] di,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             sat,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ceo,
    output logic             wrap,
`ifdef VCB_MATCH_EN
    input  logic [WIDTH-1:0] cmp,
    output logic             match,
`endif
    output logic             done
);

    vcb_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] step_q_next;
    logic             step_tc;
    logic             step_wrap;
    logic             step_en;

    // The one_shot port always decides; the default is documentation for integrators only.
    logic unused_one_shot_def;
    assign unused_one_shot_def = ONE_SHOT_DEF;

    vcb_mod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q_q),
        .up      (up),
        .sat     (sat),
        .mod_max (mod_max),
        .q_next  (step_q_next),
        .is_tc   (step_tc),
        .is_wrap (step_wrap)
    );

    assign step_en = ce & ~l & (state_q == VCB_RUN);

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        if (l) begin
            q_d     = di;
            state_d = VCB_RUN;
        end else if (step_en) begin
            q_d    = step_q_next;
            wrap_d = step_wrap;
            if (step_tc && one_shot) begin
                state_d = VCB_HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q     <= WIDTH'(VCB_RST_Q);
            state_q <= VCB_RUN;
            wrap_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef VCB_MATCH_EN
    logic match_q, match_d;

    // Pulse only on arrival at cmp, not while q sits on it.
    assign match_d = (l | step_en) & (q_d == cmp) & (q_q != cmp);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

    assign q    = q_q;
    assign tc   = step_tc;
    assign ceo  = ce & step_tc & (state_q == VCB_RUN);
    assign wrap = wrap_q;
    assign done = (state_q == VCB_HOLD);

endmodule

// File: tb/tb_vcb_mod_cled.sv
// Randomised + directed bench for vcb_mod_cled against a behavioural counter model.
module tb_vcb_mod_cled;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         clr, ce, up, l, sat, one_shot;
    logic [W-1:0] di, mod_max, cmp;
    logic [W-1:0] q;
    logic         tc, ceo, wrap, done;
    logic         match;

    logic         cas_clr, cas_ce;
    logic [W-1:0] cas_mm, cas_cmp, lo_q, hi_q;
    logic         lo_tc, lo_ceo, lo_wrap, lo_done, lo_match;
    logic         hi_tc, hi_ceo, hi_wrap, hi_done, hi_match;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Behavioural model state
    int unsigned m_q;
    bit          m_hold, m_wrap, m_match;

    always #5 clk = ~clk;

    vcb_mod_cled #(.WIDTH(W), .ONE_SHOT_DEF(1'b0)) u_dut (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .l(l), .di(di), .mod_max(mod_max),
        .sat(sat), .one_shot(one_shot), .q(q), .tc(tc), .ceo(ceo), .wrap(wrap),
`ifdef VCB_MATCH_EN
        .cmp(cmp), .match(match),
`endif
        .done(done)
    );

    vcb_mod_cled #(.WIDTH(W), .ONE_SHOT_DEF(1'b0)) u_lo (
        .clk(clk), .clr(cas_clr), .ce(cas_ce), .up(1'b1), .l(1'b0), .di('0), .mod_max(cas_mm),
        .sat(1'b0), .one_shot(1'b0), .q(lo_q), .tc(lo_tc), .ceo(lo_ceo), .wrap(lo_wrap),
`ifdef VCB_MATCH_EN
        .cmp(cas_cmp), .match(lo_match),
`endif
        .done(lo_done)
    );

    vcb_mod_cled #(.WIDTH(W), .ONE_SHOT_DEF(1'b0)) u_hi (
        .clk(clk), .clr(cas_clr), .ce(lo_ceo), .up(1'b1), .l(1'b0), .di('0), .mod_max(cas_mm),
        .sat(1'b0), .one_shot(1'b0), .q(hi_q), .tc(hi_tc), .ceo(hi_ceo), .wrap(hi_wrap),
`ifdef VCB_MATCH_EN
        .cmp(cas_cmp), .match(hi_match),
`endif
        .done(hi_done)
    );

`ifndef VCB_MATCH_EN
    assign match    = 1'b0;
    assign lo_match = 1'b0;
    assign hi_match = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_tc();
        return up ? (m_q >= 32'(mod_max)) : (m_q == 0);
    endfunction

    task automatic m_reset();
        m_q     = 0;
        m_hold  = 1'b0;
        m_wrap  = 1'b0;
        m_match = 1'b0;
    endtask

    // One clock edge of the reference counter, from the rules applied to the current inputs.
    task automatic m_edge();
        bit          t;
        bit          moved;
        int unsigned nq;
        t      = m_tc();
        nq     = m_q;
        moved  = 1'b0;
        m_wrap = 1'b0;
        if (clr) begin
            m_reset();
            return;
        end
        if (l) begin
            nq     = di;
            m_hold = 1'b0;
            moved  = 1'b1;
        end else if (ce && !m_hold) begin
            moved = 1'b1;
            if (up) nq = !t ? m_q + 1 : (sat ? 32'(mod_max) : 0);
            else    nq = !t ? m_q - 1 : (sat ? 0 : 32'(mod_max));
            m_wrap = t && !sat;
            if (t && one_shot) m_hold = 1'b1;
        end
        m_match = moved && (nq == 32'(cmp)) && (m_q != 32'(cmp));
        m_q     = nq;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_q"}, 32'(q), m_q);
        chk({tag, "_tc"}, 32'(tc), 32'(m_tc()));
        chk({tag, "_ceo"}, 32'(ceo), 32'(ce && m_tc() && !m_hold));
        chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, "_done"}, 32'(done), 32'(m_hold));
`ifdef VCB_MATCH_EN
        chk({tag, "_match"}, 32'(match), 32'(m_match));
`endif
    endtask

    task automatic tick(input string tag);
        #1;
        check_outs(tag);
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit c, input bit u, input bit ld, input int unsigned d,
                         input int unsigned mm, input bit s, input bit os);
        ce       = c;
        up       = u;
        l        = ld;
        di       = W'(d);
        mod_max  = W'(mm);
        sat      = s;
        one_shot = os;
    endtask

    initial begin
        int unsigned exp1 [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
        int unsigned exp2 [12] = '{0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
        int unsigned exp2s[5]  = '{2, 1, 0, 0, 0};
        int unsigned hi_wraps, lo_wraps, lo_matches, hi_matches;

        clr = 1'b1; cas_clr = 1'b1; cas_ce = 1'b0; cas_mm = 8'd9; cas_cmp = 8'd7; cmp = 8'd7;
        drive(0, 1, 0, 0, 4, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        tick("reset");
        clr = 1'b0; cas_clr = 1'b0;

        // Up count with wrap at mod_max=4
        drive(1, 1, 0, 0, 4, 0, 0);
        for (int i = 0; i < 12; i++) begin
            chk("t1_seq", 32'(q), exp1[i]);
            chk("t1_wrap_seq", 32'(wrap), 32'(i == 5 || i == 10));
            tick("t1");
        end

        // Down count with wrap, then saturate at 0
        drive(0, 0, 1, 0, 9, 0, 0);
        tick("t2_ld");
        drive(1, 0, 0, 0, 9, 0, 0);
        for (int i = 0; i < 12; i++) begin
            chk("t2_seq", 32'(q), exp2[i]);
            chk("t2_wrap_seq", 32'(wrap), 32'(i == 1 || i == 11));
            tick("t2");
        end
        drive(0, 0, 1, 2, 9, 1, 0);
        tick("t2s_ld");
        drive(1, 0, 0, 0, 9, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t2s_seq", 32'(q), exp2s[i]);
            chk("t2s_nowrap", 32'(wrap), 0);
            tick("t2s");
        end

        // One-shot: stop after the terminal step, resume only on load
        drive(0, 1, 1, 0, 3, 0, 1);
        tick("t3_ld");
        drive(1, 1, 0, 0, 3, 0, 1);
        repeat (4) tick("t3_run");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) one_shot = 1'b0;
            chk("t3_hold_done", 32'(done), 1);
            chk("t3_hold_q", 32'(q), 0);
            #1 chk("t3_hold_ceo", 32'(ceo), 0);
            tick("t3_hold");
        end
        drive(1, 1, 1, 2, 3, 0, 1);
        tick("t3_reload");
        chk("t3_reload_q", 32'(q), 2);
        chk("t3_reload_done", 32'(done), 0);
        drive(1, 1, 0, 0, 3, 0, 0);
        tick("t3_resume");
        chk("t3_resume_q", 32'(q), 3);

        // Load above mod_max counts as terminal
        drive(0, 1, 1, 200, 10, 0, 0);
        tick("t4_ld");
        drive(1, 1, 0, 0, 10, 0, 0);
        #1 chk("t4_tc_above", 32'(tc), 1);
        tick("t4_wrap");
        chk("t4_wrap_q", 32'(q), 0);
        drive(0, 1, 1, 200, 10, 1, 0);
        tick("t4_ld2");
        drive(1, 1, 0, 0, 10, 1, 0);
        tick("t4_sat");
        chk("t4_sat_q", 32'(q), 10);

        // Asynchronous clear mid-count
        drive(1, 1, 1, 5, 9, 0, 0);
        tick("t5_ld");
        drive(1, 1, 0, 0, 9, 0, 0);
        #2 clr = 1'b1;
        #1;
        chk("t5_async_q", 32'(q), 0);
        chk("t5_async_done", 32'(done), 0);
        m_reset();
        @(negedge clk);
        clr = 1'b0;
        tick("t5_restart");
        chk("t5_restart_q", 32'(q), 1);

        // Asynchronous clear in HOLD with a wrap pulse pending
        drive(1, 1, 1, 2, 2, 0, 1);
        tick("t5h_ld");
        drive(1, 1, 0, 0, 2, 0, 1);
        tick("t5h_term");
        chk("t5h_done_before", 32'(done), 1);
        chk("t5h_wrap_before", 32'(wrap), 1);
        #2 clr = 1'b1;
        #1;
        chk("t5h_async_q", 32'(q), 0);
        chk("t5h_async_done", 32'(done), 0);
        chk("t5h_async_wrap", 32'(wrap), 0);
        m_reset();
        @(negedge clk);
        clr = 1'b0;
        drive(1, 1, 0, 0, 2, 0, 0);
        tick("t5h_restart");

        // mod_max = 0 wraps every enabled cycle, both directions
        drive(1, 1, 0, 0, 0, 0, 0);
        repeat (3) tick("t0_up");
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (3) tick("t0_dn");

        // Two-stage decade cascade
        drive(0, 1, 0, 0, 9, 0, 0);
        hi_wraps = 0; lo_wraps = 0; lo_matches = 0; hi_matches = 0;
        for (int i = 0; i < 101; i++) begin
            cas_ce = (i < 100);
            tick("t6_idle");
            hi_wraps   += 32'(hi_wrap);
            lo_wraps   += 32'(lo_wrap);
            lo_matches += 32'(lo_match);
            hi_matches += 32'(hi_match);
            if (i == 36) begin
                chk("t6_mid_lo", 32'(lo_q), 7);
                chk("t6_mid_hi", 32'(hi_q), 3);
            end
        end
        chk("t6_hi_wraps", hi_wraps, 1);
        chk("t6_lo_wraps", lo_wraps, 10);
        chk("t6_final_lo", 32'(lo_q), 0);
        chk("t6_final_hi", 32'(hi_q), 0);
`ifdef VCB_MATCH_EN
        chk("t6_lo_matches", lo_matches, 10);
        chk("t6_hi_matches", hi_matches, 1);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            ce = ($urandom % 4) != 0;
            up = $urandom % 2;
            l  = ($urandom % 16) == 0;
            di = (($urandom % 8) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
            if (($urandom % 8) == 0)
                mod_max = (($urandom % 10) == 0) ? 8'd255 : W'($urandom_range(0, 12));
            if (($urandom % 4) == 0) sat = ~sat;
            one_shot = ($urandom % 8) == 0;
            cmp      = W'($urandom_range(0, 12));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
